bias_add_bank: RTL and testbench
================================

BIAS_ADD_BANK -- requirements
Module: bias_add_bank

Interface
REQ-001 Parameter N_CH, default 16: number of parallel channels (lanes).
REQ-002 Parameter W, default 18: lane width, signed two's complement fixed-point, same scaling for data and bias.
REQ-003 Parameter N_SETS, default 8: number of independently programmable bias sets (one per layer/tile).
REQ-004 clk  input  1  the single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cfg_we  input  1  bias write strobe.
REQ-007 cfg_set  input  clog2(N_SETS)  set index of the write.
REQ-008 cfg_ch  input  clog2(N_CH)  channel index of the write.
REQ-009 cfg_data  input  W  bias value to store.
REQ-010 sel_set  input  clog2(N_SETS)  bias set applied to the current input beat.
REQ-011 relu_en  input  1  clamps negative results to 0 when high.
REQ-012 in_valid / in_ready  input / output  1 / 1  upstream handshake.
REQ-013 in_data  input  N_CH*W  lane k at bits [W*(k+1)-1 : W*k].
REQ-014 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-015 out_data  output  N_CH*W  biased, saturated lanes, same packing as in_data.

Function
REQ-016 The block SHALL hold an N_SETS x N_CH x W bias store, written only when cfg_we=1, on that clock edge.
REQ-017 A beat SHALL be accepted when in_valid and in_ready are both 1; sel_set and relu_en SHALL be sampled on that cycle.
REQ-018 Stage 1 SHALL register, per lane, the (W+1)-bit sign-extended sum of in_data lane and bias[sel_set][lane].
REQ-019 Stage 2 SHALL saturate each sum to [-2^(W-1), 2^(W-1)-1], apply ReLU if the sampled relu_en=1, and register the result on out_data.
REQ-020 Latency SHALL be 2 cycles from acceptance to out_valid when out_ready stays 1; throughput SHALL be one beat per cycle.
REQ-021 A stage SHALL advance when it is empty or its downstream is consuming; in_ready = !s1_valid OR s1 advancing; a combinational out_ready->in_ready path is allowed.
REQ-022 Under out_ready=0, out_data and out_valid SHALL hold stable; at most 2 beats are buffered; beat order SHALL be preserved.
REQ-023 A bias write and a beat acceptance on the same cycle addressing the same set/channel SHALL use the old bias; the new value applies from the next accepted beat.
REQ-024 Bias writes SHALL never stall or corrupt beats already in the pipeline.
REQ-025 Out-of-range cfg_set/cfg_ch/sel_set (non-power-of-two parameters) SHALL be ignored on write and read bias 0.

Reset
REQ-026 When rst=1, both stage valids, out_valid and out_data SHALL be cleared to 0 on the next edge.
REQ-027 When rst=1, every bias entry SHALL be cleared to 0; a cfg_we asserted in the same cycle SHALL be ignored.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts; beats in flight at reset SHALL be discarded.

Structure
REQ-029 Package bias_pkg SHALL hold default W, N_CH, N_SETS and the SAT_MAX/SAT_MIN constants derived from W.
REQ-030 One sub-module, bias_sat_lane (saturate + ReLU on a single lane), SHALL be instantiated N_CH times.

Verification
REQ-031 Write ch0 set0 = 508 (18'b000000000111111100); feed lane0 = 100 with sel_set=0 -> out lane0 = 608 exactly 2 cycles later.
REQ-032 Bias 1000 and input 131000 -> 131071; bias -5 and input -131072 -> -131072 (both saturate).
REQ-033 relu_en=1 with bias -300 and input 100 -> 0; the same beat with relu_en=0 -> -200.
REQ-034 Hold out_ready=0 and offer 3 consecutive beats -> only 2 accepted and in_ready=0; release out_ready -> 3 outputs in order with no loss or duplication.
REQ-035 Write set2 ch5 = 7 on the same cycle a sel_set=2 beat is accepted with old bias 3 and input 10 -> 13; next beat with input 10 -> 17.
REQ-036 Assert rst with 2 beats in flight -> out_valid=0 and all bias entries 0 on the next edge; a later beat with input 42 -> 42.

Source files
------------

// File: rtl/bias_pkg.sv
// Shared defaults and saturation bounds for the bias-add bank.
// The index-width helper keeps a one-entry dimension at one address bit.
package bias_pkg;

   localparam int BIAS_W      = 18;
   localparam int BIAS_N_CH   = 16;
   localparam int BIAS_N_SETS = 8;

   localparam logic signed [BIAS_W-1:0] SAT_MAX = {1'b0, {(BIAS_W-1){1'b1}}};
   localparam logic signed [BIAS_W-1:0] SAT_MIN = {1'b1, {(BIAS_W-1){1'b0}}};

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bias_sat_lane.sv
// One lane of the output stage: clamp a (W+1)-bit sum to W bits, then optional ReLU.
module bias_sat_lane #(
   parameter int W = 18
) (
   input  logic signed [W:0]   i_sum,
   input  logic                i_relu,
   output logic signed [W-1:0] o_data
);

   // Overflow is visible as a disagreement between the two top bits of the sum.
   function automatic logic signed [W-1:0] sat(input logic signed [W:0] x);
      if (x[W] == x[W-1])
         return x[W-1:0];
      else if (x[W])
         return {1'b1, {(W-1){1'b0}}};
      else
         return {1'b0, {(W-1){1'b1}}};
   endfunction

   function automatic logic signed [W-1:0] relu(input logic signed [W-1:0] x,
                                                input logic en);
      return (en && x[W-1]) ? '0 : x;
   endfunction

   assign o_data = relu(sat(i_sum), i_relu);

endmodule

// File: rtl/bias_add_bank.sv
// N_CH-lane bias add with per-set programmable biases, saturation and optional ReLU.
// Two-stage valid/ready pipeline: stage 1 holds raw sums, stage 2 holds final lanes.
module bias_add_bank
   import bias_pkg::*;
#(
   parameter  int N_CH   = BIAS_N_CH,
   parameter  int W      = BIAS_W,
   parameter  int N_SETS = BIAS_N_SETS,
   localparam int SW     = idx_w(N_SETS),
   localparam int CW     = idx_w(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [SW-1:0]     cfg_set,
   input  logic [CW-1:0]     cfg_ch,
   input  logic [W-1:0]      cfg_data,
   input  logic [SW-1:0]     sel_set,
   input  logic              relu_en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_CH*W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_CH*W-1:0] out_data
);

   logic signed [W-1:0] r_bias [N_SETS][N_CH];

   logic              w_set_ok, w_ch_ok, w_sel_ok;
   logic              w_adv_p1, w_adv_p2, w_acc;
   logic signed [W:0] w_sum_p0 [N_CH];
   logic signed [W:0] r_sum_p1 [N_CH];
   logic              r_relu_p1;
   logic              r_vld_p1, r_vld_p2;
   logic [N_CH*W-1:0] w_sat_p1;
   logic [N_CH*W-1:0] r_out_p2;

   // Range checks only exist when a dimension is not a power of two.
   generate
      if ((1 << SW) == N_SETS) begin : g_set_full
         assign w_set_ok = 1'b1;
         assign w_sel_ok = 1'b1;
      end else begin : g_set_part
         localparam logic [SW:0] SET_LIM = N_SETS[SW:0];
         assign w_set_ok = ({1'b0, cfg_set} < SET_LIM);
         assign w_sel_ok = ({1'b0, sel_set} < SET_LIM);
      end
      if ((1 << CW) == N_CH) begin : g_ch_full
         assign w_ch_ok = 1'b1;
      end else begin : g_ch_part
         localparam logic [CW:0] CH_LIM = N_CH[CW:0];
         assign w_ch_ok = ({1'b0, cfg_ch} < CH_LIM);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < N_SETS; s++)
            for (int c = 0; c < N_CH; c++)
               r_bias[s][c] <= '0;
      end else if (cfg_we && w_set_ok && w_ch_ok) begin
         r_bias[cfg_set][cfg_ch] <= cfg_data;
      end
   end

   assign w_adv_p2 = !r_vld_p2 || out_ready;
   assign w_adv_p1 = !r_vld_p1 || w_adv_p2;
   assign in_ready = w_adv_p1;
   assign w_acc    = in_valid && w_adv_p1;

   // ---- p0 -> p1: sign-extended lane + bias (bias store read before any same-edge write)
   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         logic signed [W-1:0] b;
         logic signed [W-1:0] d;
         b = w_sel_ok ? r_bias[sel_set][k] : '0;
         d = in_data[k*W +: W];
         w_sum_p0[k] = {d[W-1], d} + {b[W-1], b};
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_sum_p1  <= w_sum_p0;
         r_relu_p1 <= relu_en;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
      end else begin
         if (w_adv_p1) r_vld_p1 <= in_valid;
         if (w_adv_p2) r_vld_p2 <= r_vld_p1;
      end
   end

   // ---- p1 -> p2: saturate, ReLU, register onto the output bus
   generate
      for (genvar k = 0; k < N_CH; k++) begin : g_lane
         bias_sat_lane #(.W(W)) u_lane (
            .i_sum  (r_sum_p1[k]),
            .i_relu (r_relu_p1),
            .o_data (w_sat_p1[k*W +: W])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst)
         r_out_p2 <= '0;
      else if (w_adv_p2 && r_vld_p1)
         r_out_p2 <= w_sat_p1;
   end

   assign out_valid = r_vld_p2;
   assign out_data  = r_out_p2;

endmodule

// File: tb/tb_bias_add_bank.sv
// Bench for bias_add_bank: table-driven lane vectors, directed stall/write/reset sequences,
// and a scoreboard fed by an independent bias model at every accepted beat.
module tb_bias_add_bank;
   import bias_pkg::*;

   localparam int NC = BIAS_N_CH;
   localparam int WW = BIAS_W;
   localparam int NS = BIAS_N_SETS;
   localparam int NW = NC * WW;

   logic          clk = 1'b0;
   logic          rst, cfg_we, relu_en, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]    cfg_set, sel_set;
   logic [3:0]    cfg_ch;
   logic [WW-1:0] cfg_data;
   logic [NW-1:0] in_data, out_data;

   bias_add_bank #(.N_CH(NC), .W(WW), .N_SETS(NS)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_set   (cfg_set),
      .cfg_ch    (cfg_ch),
      .cfg_data  (cfg_data),
      .sel_set   (sel_set),
      .relu_en   (relu_en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   int            total = 0;
   int            bad   = 0;
   int            n_out = 0;
   int            mb [NS][NC];
   logic [NW-1:0] sbq [$];
   bit            hold_prev = 1'b0;
   logic [NW-1:0] data_prev = '0;

   task automatic chk(input string nm, input logic [NW-1:0] got, input logic [NW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0b exp=%0b", nm, got, exp);
      end
   endtask

   task automatic chki(input string nm, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   function automatic int lane(input logic [NW-1:0] d, input int k);
      logic signed [WW-1:0] t;
      t = d[k*WW +: WW];
      return int'(t);
   endfunction

   function automatic logic [NW-1:0] model(input logic [NW-1:0] d, input int s, input bit r);
      logic [NW-1:0] res;
      int            v;
      res = '0;
      for (int k = 0; k < NC; k++) begin
         v = lane(d, k) + mb[s][k];
         if (v > int'(SAT_MAX)) v = int'(SAT_MAX);
         if (v < int'(SAT_MIN)) v = int'(SAT_MIN);
         if (r && v < 0) v = 0;
         res[k*WW +: WW] = v[WW-1:0];
      end
      return res;
   endfunction

   // Scoreboard and bias model, sampled mid-cycle while inputs are stable.
   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
         hold_prev = 1'b0;
         for (int s = 0; s < NS; s++)
            for (int c = 0; c < NC; c++)
               mb[s][c] = 0;
      end else begin
         if (hold_prev) begin
            chkb("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, data_prev);
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chkb("sb_extra_output", 1'b1, 1'b0);
            end else begin
               chk("sb_out", out_data, sbq.pop_front());
               n_out++;
            end
         end
         if (in_valid && in_ready)
            sbq.push_back(model(in_data, int'(sel_set), relu_en));
         if (cfg_we)
            mb[cfg_set][cfg_ch] = int'(signed'(cfg_data));
         hold_prev = out_valid && !out_ready;
         data_prev = out_data;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int s, input int c, input int v);
      cfg_we   = 1'b1;
      cfg_set  = 3'(s);
      cfg_ch   = 4'(c);
      cfg_data = v[WW-1:0];
      tick();
      cfg_we   = 1'b0;
   endtask

   function automatic logic [NW-1:0] rnd_vec();
      logic [NW-1:0] d;
      logic [31:0]   r;
      for (int k = 0; k < NC; k++) begin
         r = $urandom;
         d[k*WW +: WW] = r[WW-1:0];
      end
      return d;
   endfunction

   typedef struct {
      int set;
      int ch;
      int bias;
      int din;
      bit relu;
      int exp;
   } vec_t;

   vec_t          tbl [9];
   logic [NW-1:0] d, d2;
   int            n0, v;

   initial begin
      tbl[0] = '{0,  0,     508,     100, 1'b0,     608};
      tbl[1] = '{1,  3,    1000,  131000, 1'b0,  131071};
      tbl[2] = '{1,  4,      -5, -131072, 1'b0, -131072};
      tbl[3] = '{3,  7,    -300,     100, 1'b1,       0};
      tbl[4] = '{3,  7,    -300,     100, 1'b0,    -200};
      tbl[5] = '{4, 15,      -1,       0, 1'b1,       0};
      tbl[6] = '{5,  2,  -20000,    5000, 1'b0,  -15000};
      tbl[7] = '{7,  9,  131071,  131071, 1'b0,  131071};
      tbl[8] = '{6,  1, -131072, -131072, 1'b1,       0};

      rst = 1'b1; cfg_we = 1'b0; cfg_set = '0; cfg_ch = '0; cfg_data = '0;
      sel_set = '0; relu_en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      tick();
      tick();
      chkb("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, '0);
      rst = 1'b0;
      #1;
      chkb("rst_in_ready", in_ready, 1'b1);

      // Table vectors: one lane under test, random traffic on the other lanes.
      for (int i = 0; i < 9; i++) begin
         wr(tbl[i].set, tbl[i].ch, tbl[i].bias);
         d = rnd_vec();
         v = tbl[i].din;
         d[tbl[i].ch*WW +: WW] = v[WW-1:0];
         in_valid = 1'b1; in_data = d; sel_set = 3'(tbl[i].set); relu_en = tbl[i].relu;
         tick();
         in_valid = 1'b0;
         chkb($sformatf("vec%0d_lat1", i), out_valid, 1'b0);
         tick();
         chkb($sformatf("vec%0d_lat2", i), out_valid, 1'b1);
         chki($sformatf("vec%0d_lane", i), lane(out_data, tbl[i].ch), tbl[i].exp);
         tick();
      end

      // Backpressure: three beats offered, two fit, order preserved on release.
      n0 = n_out;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = rnd_vec(); sel_set = 3'd1; relu_en = 1'b0;
      #1 chkb("stall_rdy_a", in_ready, 1'b1);
      tick();
      in_data = rnd_vec(); sel_set = 3'd3; relu_en = 1'b1;
      #1 chkb("stall_rdy_b", in_ready, 1'b1);
      tick();
      in_data = rnd_vec(); sel_set = 3'd5; relu_en = 1'b0;
      #1 chkb("stall_rdy_c", in_ready, 1'b0);
      tick();
      chkb("stall_rdy_c2", in_ready, 1'b0);
      chkb("stall_out_valid", out_valid, 1'b1);
      tick();
      out_ready = 1'b1;
      #1 chkb("stall_release_rdy", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      for (int t = 0; t < 10 && sbq.size() != 0; t++) tick();
      tick();
      chki("stall_count", n_out - n0, 3);

      // Same-edge write and read of one bias entry: old value first, new value next beat.
      wr(2, 5, 3);
      d = '0;
      d[5*WW +: WW] = 18'd10;
      cfg_we = 1'b1; cfg_set = 3'd2; cfg_ch = 4'd5; cfg_data = 18'd7;
      in_valid = 1'b1; in_data = d; sel_set = 3'd2; relu_en = 1'b0;
      tick();
      cfg_we = 1'b0;
      tick();
      in_valid = 1'b0;
      chki("wr_race_old", lane(out_data, 5), 13);
      tick();
      chki("wr_race_new", lane(out_data, 5), 17);
      tick();

      // Reset with two beats in flight and a write that must be ignored.
      in_valid = 1'b1; in_data = rnd_vec(); sel_set = 3'd1;
      tick();
      in_data = rnd_vec(); sel_set = 3'd3;
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      cfg_we = 1'b1; cfg_set = 3'd2; cfg_ch = 4'd5; cfg_data = 18'd99;
      tick();
      cfg_we = 1'b0;
      chkb("rst_flight_valid", out_valid, 1'b0);
      chk("rst_flight_data", out_data, '0);
      rst = 1'b0;
      #1 chkb("rst_flight_rdy", in_ready, 1'b1);
      d = '0;
      d[5*WW +: WW] = 18'd42;
      d2 = '0;
      for (int k = 0; k < NC; k++) d2[k*WW +: WW] = 18'd42;
      in_valid = 1'b1; in_data = d; sel_set = 3'd2; relu_en = 1'b0;
      tick();
      in_data = d2; sel_set = 3'd1;
      tick();
      in_valid = 1'b0;
      chki("post_rst_lane5", lane(out_data, 5), 42);
      chk("post_rst_set2", out_data, d);
      tick();
      chk("post_rst_set1", out_data, d2);
      tick();

      // Random traffic with random backpressure and interleaved bias writes.
      for (int t = 0; t < 300; t++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         in_data   = rnd_vec();
         sel_set   = 3'($urandom_range(0, NS-1));
         relu_en   = $urandom_range(0, 1) == 1;
         out_ready = ($urandom_range(0, 3) != 0);
         cfg_we    = ($urandom_range(0, 4) == 0);
         cfg_set   = 3'($urandom_range(0, NS-1));
         cfg_ch    = 4'($urandom_range(0, NC-1));
         cfg_data  = 18'($urandom);
         tick();
      end
      in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
      for (int t = 0; t < 10 && sbq.size() != 0; t++) tick();
      tick();
      chki("sb_empty", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
